// File: rtl/fetch_if.sv
// fetch_if: bundle of the fetch unit's memory, redirect and decoder ports.
//   master modport: fetch unit side (drives imem_req/imem_addr and the inst_* head).
//   slave modport : environment side (memory, branch unit, decoder).
//   imem_req/imem_addr/imem_ack/imem_rdata : req/ack instruction memory handshake
//   redirect_valid/redirect_base/redirect_off : branch redirect, target = base + (off << 2)
//   inst_valid/inst_ready/inst_pc/inst_data : {pc, instruction} toward the decoder
interface fetch_if #(
    parameter int XLEN = 32,
    parameter int IW   = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [IW-1:0]   imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_off;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [IW-1:0]   inst_data;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_base, redirect_off,
        output inst_valid, inst_pc, inst_data,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_base, redirect_off,
        input  inst_valid, inst_pc, inst_data,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   Owns the fetch PC, issues req/ack fetches to a variable-latency memory,
//   buffers up to DEPTH fetched words in a prefetch FIFO and presents the
//   oldest {pc, instruction} to the decoder over valid/ready. A branch
//   redirect flushes the FIFO and discards data of any in-flight request.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_if.master (memory handshake, redirect, decoder handoff)
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0100,
    parameter int              PC_STEP  = 4
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_s;
    logic            req_r, req_s;
    logic [XLEN-1:0] addr_r, addr_s;

    logic [CW-1:0]   count_r, count_s;
    logic [AW-1:0]   head_r, tail_r;
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [IW-1:0]   data_mem_r [DEPTH];

    logic            push_s, pop_s, has_space_s;
    logic [XLEN-1:0] target_s, pc_inc_s;

    assign target_s = bus.redirect_base + (bus.redirect_off << 2);
    assign pc_inc_s = fetch_pc_r + XLEN'(PC_STEP);

    // A redirect suppresses both the push of ack data and a same-cycle pop.
    assign push_s = (state_r == ST_WAIT) && bus.imem_ack && !bus.redirect_valid;
    assign pop_s  = (count_r != {CW{1'b0}}) && bus.inst_ready && !bus.redirect_valid;

    // Occupancy after this cycle's push/pop (or flush); gates new requests.
    always_comb begin
        count_s = count_r;
        if (bus.redirect_valid) begin
            count_s = {CW{1'b0}};
        end else begin
            count_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign has_space_s = (count_s != CW'(DEPTH));

    // Next-state, next PC and next request/address.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        req_s      = req_r;
        addr_s     = addr_r;
        if (bus.redirect_valid) begin
            fetch_pc_s = target_s;
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_WAIT: begin
                    if (bus.imem_ack) begin
                        req_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_DROP: begin
                    // The outstanding handshake may still complete here.
                    if (bus.imem_ack) begin
                        req_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (has_space_s) begin
                        req_s   = 1'b1;
                        addr_s  = fetch_pc_r;
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ack) begin
                        fetch_pc_s = pc_inc_s;
                        if (has_space_s) begin
                            addr_s  = pc_inc_s;
                            state_s = ST_WAIT;
                        end else begin
                            req_s   = 1'b0;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack) begin
                        req_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, PC and memory request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            req_r      <= req_s;
            addr_r     <= addr_s;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (bus.redirect_valid) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + 1'b1;
            end
            if (pop_s) begin
                head_r <= head_r + 1'b1;
            end
            count_r <= count_s;
        end
    end

    // FIFO storage; the pushed PC is the address of the acknowledged request.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]   <= addr_r;
            data_mem_r[tail_r] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req   = req_r;
    assign bus.imem_addr  = addr_r;
    assign bus.inst_valid = (count_r != {CW{1'b0}});
    assign bus.inst_pc    = bus.inst_valid ? pc_mem_r[head_r]   : {XLEN{1'b0}};
    assign bus.inst_data  = bus.inst_valid ? data_mem_r[head_r] : {IW{1'b0}};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit.
//   dut0: default parameters, driven by a latency-configurable memory model.
//   dut1: RESET_PC = 0xFFFFFFFC with a zero-wait memory, for PC wrap.
//   The reference model tracks only the next PC the decoder should see:
//   sequential +4, replaced by the redirect target, with instruction data
//   a fixed function of its PC.
module tb_fetch_unit;
    localparam int XLEN = 32;
    localparam int IW   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if #(.XLEN(XLEN), .IW(IW)) u ();
    fetch_if #(.XLEN(XLEN), .IW(IW)) v ();

    fetch_unit #(.XLEN(XLEN), .IW(IW), .DEPTH(4), .RESET_PC(32'h0000_0100), .PC_STEP(4))
        dut0 (.clk(clk), .rst(rst), .bus(u.master));
    fetch_unit #(.XLEN(XLEN), .IW(IW), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4))
        dut1 (.clk(clk), .rst(rst), .bus(v.master));

    int          n_cmp = 0;
    int          n_err = 0;
    int          fixed_lat = 0;
    int          cur_lat = 0;
    int          wait_cnt = 0;
    bit          rand_lat = 1'b0;
    logic [31:0] exp_pc;
    int          n_pop = 0;
    int          n_ack = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called and returns at a negative edge.
    task automatic tick();
        logic        pr, pk, prd;
        logic [31:0] pa;
        if (u.imem_req) u.imem_ack = (wait_cnt >= cur_lat);
        else            u.imem_ack = 1'b0;
        u.imem_rdata = u.imem_ack ? memfn(u.imem_addr) : $urandom;
        v.imem_ack   = v.imem_req;
        v.imem_rdata = memfn(v.imem_addr);
        pr  = u.imem_req;
        pa  = u.imem_addr;
        pk  = u.imem_ack;
        prd = u.redirect_valid;
        if (prd) begin
            exp_pc = u.redirect_base + (u.redirect_off << 2);
        end else if (u.inst_valid && u.inst_ready) begin
            chk("pop_pc", u.inst_pc, exp_pc);
            chk("pop_data", u.inst_data, memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (pr && pk) n_ack++;
        @(posedge clk);
        if (pr && pk) begin
            wait_cnt = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (pr) begin
            wait_cnt++;
        end
        @(negedge clk);
        if (pr && !pk) begin
            chk("hold_req", u.imem_req, 1);
            chk("hold_addr", u.imem_addr, pa);
        end
        if (prd) chk("flush_valid", u.inst_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", u.imem_req, 0);
        chk("rst_addr", u.imem_addr, 0);
        chk("rst_valid", u.inst_valid, 0);
        chk("rst_pc", u.inst_pc, 0);
        chk("rst_data", u.inst_data, 0);
        u.redirect_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        exp_pc   = 32'h0000_0100;
        wait_cnt = 0;
        cur_lat  = fixed_lat;
        n_pop    = 0;
        n_ack    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        u.imem_ack = 1'b0; u.imem_rdata = '0;
        u.redirect_valid = 1'b0; u.redirect_base = '0; u.redirect_off = '0;
        u.inst_ready = 1'b1;
        v.imem_ack = 1'b0; v.imem_rdata = '0;
        v.redirect_valid = 1'b0; v.redirect_base = '0; v.redirect_off = '0;
        v.inst_ready = 1'b1;

        // Reset release, zero-wait memory, decoder always ready; dut1 wraps.
        fixed_lat = 0; rand_lat = 1'b0;
        do_reset();
        tick();
        chk("t1_req", u.imem_req, 1);
        chk("t1_addr0", u.imem_addr, 32'h100);
        chk("t5_addr0", v.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t1_addr1", u.imem_addr, 32'h104);
        chk("t1_valid", u.inst_valid, 1);
        chk("t1_pc0", u.inst_pc, 32'h100);
        chk("t1_data0", u.inst_data, memfn(32'h100));
        chk("t5_addr1", v.imem_addr, 32'h0);
        chk("t5_pc0", v.inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("t1_addr2", u.imem_addr, 32'h108);
        chk("t1_pc1", u.inst_pc, 32'h104);
        chk("t5_pc1", v.inst_pc, 32'h0);
        tick(); tick();

        // Decoder stalled: FIFO fills with exactly four words then stops.
        u.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("t2_req_off", u.imem_req, 0);
        chk("t2_acks", n_ack, 4);
        chk("t2_valid", u.inst_valid, 1);
        chk("t2_head", u.inst_pc, 32'h100);
        u.inst_ready = 1'b1;
        tick();
        chk("t2_req_on", u.imem_req, 1);
        chk("t2_addr", u.imem_addr, 32'h110);
        for (int i = 0; i < 8; i++) tick();
        chk("t2_pops", n_pop, 9);

        // Redirect with three entries buffered and a request in flight.
        u.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("t3_pc_pre", u.inst_pc, 32'h100);
        chk("t3_addr_pre", u.imem_addr, 32'h10C);
        u.redirect_valid = 1'b1; u.redirect_base = 32'h100; u.redirect_off = 32'hFFFF_FFFE;
        tick();
        chk("t3_valid", u.inst_valid, 0);
        chk("t3_req_off", u.imem_req, 0);
        u.redirect_valid = 1'b0; u.inst_ready = 1'b1;
        tick();
        chk("t3_addr", u.imem_addr, 32'hF8);
        tick();
        chk("t3_first_pc", u.inst_pc, 32'hF8);
        for (int i = 0; i < 3; i++) tick();

        // Latency-3 memory, redirect while waiting on 0x104.
        fixed_lat = 3;
        do_reset();
        for (int i = 0; i < 20 && u.imem_addr != 32'h104; i++) tick();
        chk("t4_addr104", u.imem_addr, 32'h104);
        tick();
        u.redirect_valid = 1'b1; u.redirect_base = 32'h200; u.redirect_off = 32'd4;
        tick();
        u.redirect_valid = 1'b0;
        chk("t4_held", u.imem_addr, 32'h104);
        a0 = n_ack;
        for (int i = 0; i < 10 && n_ack == a0; i++) tick();
        chk("t4_ack_seen", (n_ack != a0), 1);
        chk("t4_req_off", u.imem_req, 0);
        for (int i = 0; i < 10 && !u.imem_req; i++) tick();
        chk("t4_addr", u.imem_addr, 32'h210);
        for (int i = 0; i < 20 && !u.inst_valid; i++) tick();
        chk("t4_first_pc", u.inst_pc, 32'h210);
        tick();

        // Reset asserted between edges while a request is outstanding.
        fixed_lat = 1; u.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("t6_req_pre", u.imem_req, 1);
        chk("t6_valid_pre", u.inst_valid, 1);
        #2;
        do_reset();
        tick();
        chk("t6_req", u.imem_req, 1);
        chk("t6_addr", u.imem_addr, 32'h100);

        // Random latency, decoder stalls and redirects.
        rand_lat = 1'b1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            u.inst_ready = (($urandom % 4) != 0);
            if (($urandom % 16) == 0) begin
                u.redirect_valid = 1'b1;
                u.redirect_base  = $urandom;
                u.redirect_off   = 32'($urandom_range(0, 63)) - 32'd32;
            end else begin
                u.redirect_valid = 1'b0;
            end
            tick();
        end
        u.redirect_valid = 1'b0;
        chk("rand_pops", (n_pop > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
